// File: rtl/mlp_layer_sequencer_if.sv
// Datapath-side bus between the MLP layer sequencer and the shared MAC/ROM/RAM datapath.
// The sequencer is the master; the datapath returns the accumulator result.
interface mlp_layer_sequencer_if #(
    parameter int IN_DIM  = 784,
    parameter int HID_DIM = 128,
    parameter int OUT_DIM = 10,
    parameter int ACC_W   = 32
);
    // Index widths cover both layers, so small network shapes never truncate an address.
    localparam int IN_AW = $clog2((IN_DIM > HID_DIM) ? IN_DIM : HID_DIM);
    localparam int W_AW  = $clog2((IN_DIM * HID_DIM > HID_DIM * OUT_DIM) ?
                                  IN_DIM * HID_DIM : HID_DIM * OUT_DIM);
    localparam int WB_AW = $clog2((HID_DIM > OUT_DIM) ? HID_DIM : OUT_DIM);

    logic                    layer_sel;
    logic [IN_AW-1:0]        in_addr;
    logic [W_AW-1:0]         w_addr;
    logic                    mac_clear;
    logic                    mac_en;
    logic signed [ACC_W-1:0] acc_in;
    logic                    wb_en;
    logic [WB_AW-1:0]        wb_addr;

    modport master (
        output layer_sel, in_addr, w_addr, mac_clear, mac_en, wb_en, wb_addr,
        input  acc_in
    );

    modport slave (
        input  layer_sel, in_addr, w_addr, mac_clear, mac_en, wb_en, wb_addr,
        output acc_in
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Control FSM that walks the shared MAC datapath through both fully-connected MLP layers
// and keeps a running argmax over the output-layer scores.
module mlp_layer_sequencer #(
    parameter int IN_DIM  = 784,
    parameter int HID_DIM = 128,
    parameter int OUT_DIM = 10,
    parameter int ACC_W   = 32,
    parameter int ROM_LAT = 1,
    parameter int MAC_LAT = 1
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic [3:0] inference_index,
    output logic       output_en,
    mlp_layer_sequencer_if.master dp
);
    localparam int IN_AW  = $clog2((IN_DIM > HID_DIM) ? IN_DIM : HID_DIM);
    localparam int W_AW   = $clog2((IN_DIM * HID_DIM > HID_DIM * OUT_DIM) ?
                                   IN_DIM * HID_DIM : HID_DIM * OUT_DIM);
    localparam int WB_AW  = $clog2((HID_DIM > OUT_DIM) ? HID_DIM : OUT_DIM);
    localparam int WB_LEN = ROM_LAT + MAC_LAT;
    localparam int WB_CW  = $clog2(WB_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L0_MAC,
        S_L0_WB,
        S_L1_MAC,
        S_L1_WB,
        S_DONE
    } state_e;

    state_e                  state_q,    state_d;
    logic [IN_AW-1:0]        k_q,        k_d;
    logic [W_AW-1:0]         w_addr_q,   w_addr_d;
    logic [WB_AW-1:0]        neuron_q,   neuron_d;
    logic [WB_CW-1:0]        wb_cnt_q,   wb_cnt_d;
    logic [ROM_LAT-1:0]      issue_q,    issue_d;
    logic [ROM_LAT-1:0]      clear_q,    clear_d;
    logic signed [ACC_W-1:0] best_q,     best_d;
    logic [3:0]              idx_q,      idx_d;
    logic [3:0]              index_q,    index_d;
    logic                    out_en_q,   out_en_d;

    logic in_l1;
    logic issuing;
    logic last_k;
    logic last_neuron;
    logic wb_fire;

    always_comb begin
        in_l1       = (state_q == S_L1_MAC) || (state_q == S_L1_WB) || (state_q == S_DONE);
        issuing     = (state_q == S_L0_MAC) || (state_q == S_L1_MAC);
        last_k      = in_l1 ? (k_q == IN_AW'(HID_DIM - 1)) : (k_q == IN_AW'(IN_DIM - 1));
        last_neuron = in_l1 ? (neuron_q == WB_AW'(OUT_DIM - 1))
                            : (neuron_q == WB_AW'(HID_DIM - 1));
        wb_fire     = ((state_q == S_L0_WB) || (state_q == S_L1_WB)) &&
                      (wb_cnt_q == WB_CW'(WB_LEN - 1));
    end

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        k_d      = k_q;
        w_addr_d = w_addr_q;
        neuron_d = neuron_q;
        wb_cnt_d = wb_cnt_q;
        best_d   = best_q;
        idx_d    = idx_q;
        index_d  = index_q;
        out_en_d = out_en_q;

        // Operand data lands ROM_LAT cycles after its address, so the MAC strobes trail the issue.
        issue_d = (issue_q << 1) | ROM_LAT'(issuing);
        clear_d = (clear_q << 1) | ROM_LAT'(issuing && (k_q == '0));

        if (wb_fire && (state_q == S_L1_WB) &&
            ((neuron_q == '0) || ($signed(dp.acc_in) > best_q))) begin
            best_d = $signed(dp.acc_in);
            idx_d  = 4'(neuron_q);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_L0_MAC;
                    k_d      = '0;
                    w_addr_d = '0;
                    neuron_d = '0;
                    out_en_d = 1'b0;
                end
            end
            S_L0_MAC, S_L1_MAC: begin
                if (last_k) begin
                    state_d  = (state_q == S_L0_MAC) ? S_L0_WB : S_L1_WB;
                    wb_cnt_d = '0;
                end else begin
                    k_d      = k_q + IN_AW'(1);
                    w_addr_d = w_addr_q + W_AW'(1);
                end
            end
            S_L0_WB, S_L1_WB: begin
                if (!wb_fire) begin
                    wb_cnt_d = wb_cnt_q + WB_CW'(1);
                end else if (!last_neuron) begin
                    // Weights of consecutive neurons are contiguous, so w_addr just keeps counting.
                    state_d  = (state_q == S_L0_WB) ? S_L0_MAC : S_L1_MAC;
                    neuron_d = neuron_q + WB_AW'(1);
                    k_d      = '0;
                    w_addr_d = w_addr_q + W_AW'(1);
                end else if (state_q == S_L0_WB) begin
                    state_d  = S_L1_MAC;
                    neuron_d = '0;
                    k_d      = '0;
                    w_addr_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                index_d  = idx_q;
                out_en_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking updates make every flop sample pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            w_addr_q <= '0;
            neuron_q <= '0;
            wb_cnt_q <= '0;
            issue_q  <= '0;
            clear_q  <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            index_q  <= '0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            w_addr_q <= w_addr_d;
            neuron_q <= neuron_d;
            wb_cnt_q <= wb_cnt_d;
            issue_q  <= issue_d;
            clear_q  <= clear_d;
            best_q   <= best_d;
            idx_q    <= idx_d;
            index_q  <= index_d;
            out_en_q <= out_en_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign inference_index = index_q;
    assign output_en       = out_en_q;

    assign dp.layer_sel = in_l1;
    assign dp.in_addr   = k_q;
    assign dp.w_addr    = w_addr_q;
    assign dp.mac_en    = issue_q[ROM_LAT-1];
    assign dp.mac_clear = clear_q[ROM_LAT-1];
    assign dp.wb_en     = wb_fire;
    assign dp.wb_addr   = neuron_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomized self-checking bench: a cycle-count model of one inference predicts every
// sequencer output each cycle; scripted score sets pin the argmax and timing by hand.
module tb_mlp_layer_sequencer;
    localparam int IN_DIM  = 4;
    localparam int HID_DIM = 3;
    localparam int OUT_DIM = 10;
    localparam int ACC_W   = 32;
    localparam int ROM_LAT = 1;
    localparam int MAC_LAT = 1;

    localparam int P0     = IN_DIM + ROM_LAT + MAC_LAT;
    localparam int P1     = HID_DIM + ROM_LAT + MAC_LAT;
    localparam int T_L1   = HID_DIM * P0;
    localparam int T_DONE = T_L1 + OUT_DIM * P1;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       busy;
    logic [3:0] inference_index;
    logic       output_en;

    mlp_layer_sequencer_if #(
        .IN_DIM(IN_DIM), .HID_DIM(HID_DIM), .OUT_DIM(OUT_DIM), .ACC_W(ACC_W)
    ) dp ();

    mlp_layer_sequencer #(
        .IN_DIM(IN_DIM), .HID_DIM(HID_DIM), .OUT_DIM(OUT_DIM),
        .ACC_W(ACC_W), .ROM_LAT(ROM_LAT), .MAC_LAT(MAC_LAT)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .inference_index(inference_index),
        .output_en      (output_en),
        .dp             (dp)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_vec = 0;
    int n_err = 0;

    int scores    [OUT_DIM];
    int s_ties    [OUT_DIM] = '{-5, 3, 9, 9, -1, 0, 2, 8, 1, 4};
    int s_negative[OUT_DIM] = '{-100, -100, -100, -100, -100, -100, -100, -3, -100, -100};

    // Model state: cycles since the accepted start (-1 when idle) and the expected result.
    int         t_m     = -1;
    bit         oe_m    = 1'b0;
    logic [3:0] idx_m   = '0;
    bit         fresh_m = 1'b1;
    bit         armed   = 1'b0;
    int         cyc     = 0;
    int         wb_count = 0;
    int         wb_times[$];

    int c_rel, c_per, c_fan, c_n, c_o;
    bit c_l1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] argmax(input int s[OUT_DIM]);
        int best = s[0];
        logic [3:0] idx = '0;
        for (int i = 1; i < OUT_DIM; i++) begin
            if (s[i] > best) begin
                best = s[i];
                idx  = 4'(i);
            end
        end
        return idx;
    endfunction

    always @(posedge CLOCK_50) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            t_m     <= -1;
            oe_m    <= 1'b0;
            idx_m   <= '0;
            fresh_m <= 1'b1;
            armed   <= 1'b1;
        end else if (t_m < 0) begin
            if (start) begin
                t_m     <= 0;
                oe_m    <= 1'b0;
                fresh_m <= 1'b0;
            end
        end else if (t_m == T_DONE) begin
            t_m   <= -1;
            oe_m  <= 1'b1;
            idx_m <= argmax(scores);
        end else begin
            t_m <= t_m + 1;
        end
    end

    always @(negedge CLOCK_50) begin
        if (armed) begin
            if (dp.wb_en) begin
                wb_count++;
                wb_times.push_back(cyc);
            end
            check("inference_index", inference_index, idx_m);
            if (t_m < 0) begin
                check("idle_busy", busy, 0);
                check("idle_mac_en", dp.mac_en, 0);
                check("idle_mac_clear", dp.mac_clear, 0);
                check("idle_wb_en", dp.wb_en, 0);
                check("idle_output_en", output_en, oe_m);
                if (fresh_m) begin
                    check("rst_layer_sel", dp.layer_sel, 0);
                    check("rst_in_addr", dp.in_addr, 0);
                    check("rst_w_addr", dp.w_addr, 0);
                    check("rst_wb_addr", dp.wb_addr, 0);
                end
            end else if (t_m == T_DONE) begin
                check("done_busy", busy, 1);
                check("done_mac_en", dp.mac_en, 0);
                check("done_wb_en", dp.wb_en, 0);
                check("done_output_en", output_en, 0);
            end else begin
                c_l1  = (t_m >= T_L1);
                c_rel = c_l1 ? t_m - T_L1 : t_m;
                c_per = c_l1 ? P1 : P0;
                c_fan = c_l1 ? HID_DIM : IN_DIM;
                c_n   = c_rel / c_per;
                c_o   = c_rel % c_per;
                check("run_busy", busy, 1);
                check("run_output_en", output_en, 0);
                check("layer_sel", dp.layer_sel, c_l1);
                check("mac_en", dp.mac_en, (c_o >= ROM_LAT) && (c_o < c_fan + ROM_LAT));
                check("mac_clear", dp.mac_clear, c_o == ROM_LAT);
                check("wb_en", dp.wb_en, c_o == c_per - 1);
                if (c_o < c_fan) begin
                    check("in_addr", dp.in_addr, 64'(c_o));
                    check("w_addr", dp.w_addr, 64'(c_n * c_fan + c_o));
                end
                if (c_o == c_per - 1) check("wb_addr", dp.wb_addr, 64'(c_n));
            end
        end
    end

    // Datapath stand-in: returns the scripted score of the neuron being written back in L1.
    always @(negedge CLOCK_50) begin
        if (dp.wb_en && dp.layer_sel) dp.acc_in = 32'(scores[dp.wb_addr]);
        else                          dp.acc_in = $urandom;
    end

    task automatic run_inference(input int poke_at);
        bit done = 1'b0;
        wb_count = 0;
        wb_times.delete();
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        for (int w = 1; w < 2000 && !done; w++) begin
            start = (poke_at > 0) && (w == poke_at);
            @(negedge CLOCK_50);
            if (output_en) done = 1'b1;
        end
        start = 1'b0;
        check("run_completes", done, 1);
    endtask

    initial begin
        bit found;
        dp.acc_in = '0;
        scores    = s_ties;

        rst_n = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        rst_n = 1'b1;
        wb_count = 0;
        repeat (20) @(negedge CLOCK_50);
        check("reset_quiet_wb_count", wb_count, 0);
        check("reset_output_en", output_en, 0);

        check("model_argmax_ties", argmax(s_ties), 2);
        check("model_argmax_negative", argmax(s_negative), 7);

        // Clean run with scripted ties: timing and result pinned by hand.
        scores = s_ties;
        run_inference(0);
        check("ties_index", inference_index, 2);
        check("ties_output_en", output_en, 1);
        check("ties_wb_count", wb_count, HID_DIM + OUT_DIM);
        if (wb_times.size() == HID_DIM + OUT_DIM) begin
            check("l0_wb_gap_a", wb_times[1] - wb_times[0], 6);
            check("l0_wb_gap_b", wb_times[2] - wb_times[1], 6);
            check("l1_wb_gap", wb_times[4] - wb_times[3], 5);
        end

        scores = s_negative;
        run_inference(0);
        check("negative_index", inference_index, 7);

        // A start pulse mid-run must not disturb the run.
        scores = s_ties;
        run_inference(50);
        check("busy_start_wb_count", wb_count, HID_DIM + OUT_DIM);
        check("busy_start_index", inference_index, 2);
        repeat (3) @(negedge CLOCK_50);

        // Reset during layer 1, then a fresh run.
        for (int i = 0; i < OUT_DIM; i++) scores[i] = int'($urandom_range(0, 20)) - 10;
        @(negedge CLOCK_50) start = 1'b1;
        @(negedge CLOCK_50) start = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 500 && !found; w++) begin
            @(negedge CLOCK_50);
            if (dp.layer_sel) found = 1'b1;
        end
        check("reach_layer1", found, 1);
        repeat (3) @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(negedge CLOCK_50) rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_mac_en", dp.mac_en, 0);
        check("midrst_wb_en", dp.wb_en, 0);
        check("midrst_index", inference_index, 0);
        wb_count = 0;
        repeat (8) @(negedge CLOCK_50);
        check("midrst_no_wb", wb_count, 0);
        run_inference(0);
        check("after_rst_index", inference_index, argmax(scores));
        check("after_rst_output_en", output_en, 1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                if (r % 2 == 0) scores[i] = int'($urandom_range(0, 8)) - 4;
                else            scores[i] = int'($urandom);
            end
            run_inference((r % 2 == 1) ? int'($urandom_range(5, 60)) : 0);
            check("random_index", inference_index, argmax(scores));
            check("random_wb_count", wb_count, HID_DIM + OUT_DIM);
            repeat (int'($urandom_range(0, 4))) @(negedge CLOCK_50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
